// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants for the instruction encoder and decoder:
// opcodes, one-hot class select indices, field widths and load-session states.
package mips_isa_pkg;

    localparam int OPC_W    = 6;
    localparam int REG_W    = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int TARGET_W = 26;
    localparam int WORD_W   = 32;
    localparam int SEL_W    = 7;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

    // Bit positions inside the one-hot class select; bit 0 has highest priority.
    localparam int SEL_RTYPE = 0;
    localparam int SEL_ORI   = 1;
    localparam int SEL_ADDIU = 2;
    localparam int SEL_LW    = 3;
    localparam int SEL_SW    = 4;
    localparam int SEL_BEQ   = 5;
    localparam int SEL_J     = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mips_ins_encoder_if.sv
// Instruction-field input handshake plus the instruction-memory write port.
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready;
// in_ready never depends on in_valid, and the producer keeps fields stable
// while in_valid is high and in_ready is low.
interface mips_ins_encoder_if #(
    parameter int AW = 32
);
    import mips_isa_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [SEL_W-1:0]      sel;
    logic [REG_W-1:0]      rs;
    logic [REG_W-1:0]      rt;
    logic [REG_W-1:0]      rd;
    logic [REG_W-1:0]      shamt;
    logic [FUNCT_W-1:0]    funct;
    logic [IMM_W-1:0]      imm;
    logic [TARGET_W-1:0]   target;
    logic                  mem_wen;
    logic [AW-1:0]         mem_addr;
    logic [WORD_W-1:0]     mem_wdata;

    modport master (
        output in_valid, sel, rs, rt, rd, shamt, funct, imm, target,
        input  in_ready, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, sel, rs, rt, rd, shamt, funct, imm, target,
        output in_ready, mem_wen, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mips_word_pack.sv
// Combinational packer: one-hot instruction class plus operand fields -> 32-bit
// MIPS word. Multi-hot selects resolve to the lowest set bit; zero gives a NOP.
// With ENC_ONEHOT_CHECK_EN defined it also flags zero/multi-hot selects.
module mips_word_pack
    import mips_isa_pkg::*;
(
    input  logic [SEL_W-1:0]    sel,
    input  logic [REG_W-1:0]    rs,
    input  logic [REG_W-1:0]    rt,
    input  logic [REG_W-1:0]    rd,
    input  logic [REG_W-1:0]    shamt,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic [IMM_W-1:0]    imm,
    input  logic [TARGET_W-1:0] target,
`ifdef ENC_ONEHOT_CHECK_EN
    output logic                illegal,
`endif
    output logic [WORD_W-1:0]   word
);

    // Priority encode the class select into the assembled word.
    always_comb begin
        word = '0;
        if (sel[SEL_RTYPE])      word = {OP_RTYPE, rs, rt, rd, shamt, funct};
        else if (sel[SEL_ORI])   word = {OP_ORI,   rs, rt, imm};
        else if (sel[SEL_ADDIU]) word = {OP_ADDIU, rs, rt, imm};
        else if (sel[SEL_LW])    word = {OP_LW,    rs, rt, imm};
        else if (sel[SEL_SW])    word = {OP_SW,    rs, rt, imm};
        else if (sel[SEL_BEQ])   word = {OP_BEQ,   rs, rt, imm};
        else if (sel[SEL_J])     word = {OP_J,     target};
    end

`ifdef ENC_ONEHOT_CHECK_EN
    // Zero select, or more than one bit set, is not a legal class.
    always_comb begin
        illegal = (sel == '0) || ((sel & (sel - SEL_W'(1))) != '0);
    end
`endif

endmodule

// File: rtl/mips_ins_encoder.sv
// MIPS instruction encoder: accepts instruction fields over a valid/ready
// handshake and streams the packed words to instruction memory at
// consecutive word addresses during a start/finish load session.
// Optional macro ENC_ONEHOT_CHECK_EN: reject zero/multi-hot selects and raise err.
module mips_ins_encoder
    import mips_isa_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DEPTH = 256,
    localparam int CW   = $clog2(DEPTH + 1)
)(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [AW-1:0]        start_addr,
    input  logic                 finish,
    mips_ins_encoder_if.slave    bus,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        word_cnt,
    output logic                 err,
    output state_t               dbg_state
);

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                wen_q, wen_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                in_ready_c;
    logic                accept;
    logic                write_ok;
    logic [WORD_W-1:0]   packed_word;
`ifdef ENC_ONEHOT_CHECK_EN
    logic                illegal;
`endif

    mips_word_pack u_pack (
        .sel     (bus.sel),
        .rs      (bus.rs),
        .rt      (bus.rt),
        .rd      (bus.rd),
        .shamt   (bus.shamt),
        .funct   (bus.funct),
        .imm     (bus.imm),
        .target  (bus.target),
`ifdef ENC_ONEHOT_CHECK_EN
        .illegal (illegal),
`endif
        .word    (packed_word)
    );

    // Next-state, handshake, address/count advance and write-port staging.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        in_ready_c = (state_q == RUN) && (cnt_q < CW'(DEPTH));
        accept     = bus.in_valid && in_ready_c;
`ifdef ENC_ONEHOT_CHECK_EN
        write_ok   = accept && !illegal;
        if (accept && illegal) err_d = 1'b1;
`else
        write_ok   = accept;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    addr_d  = start_addr & ~AW'(3);
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            RUN:   if (finish) state_d = DRAIN;
            // The only write that can be in flight here is on the port this
            // cycle and retires with it, so one DRAIN cycle always suffices.
            DRAIN: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Count and address advance with the accept, so word_cnt already shows
        // the new total while the word sits on the write port.
        if (write_ok) begin
            wen_d   = 1'b1;
            waddr_d = addr_q;
            wdata_d = packed_word;
            addr_d  = addr_q + AW'(4);
            cnt_d   = cnt_q + CW'(1);
        end
    end

    // Session registers; reset abandons any session and drops a pending write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_addr  = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign word_cnt      = cnt_q;
    assign dbg_state     = state_q;
`ifdef ENC_ONEHOT_CHECK_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_mips_ins_encoder.sv
// Self-checking bench for mips_ins_encoder (built with DEPTH=4 so the full
// condition is reachable): vector table, hand sequences and random sessions
// against a behavioural session/encoding model.
module tb_mips_ins_encoder;
    import mips_isa_pkg::*;

    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [6:0]  sel;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } fld_t;

    typedef struct {
        fld_t        f;
        logic [31:0] exp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    logic start, finish;
    logic [AW-1:0] start_addr;
    logic busy, done, err;
    logic [CW-1:0] word_cnt;
    state_t dbg_state;

    always #5 clk = ~clk;

    mips_ins_encoder_if #(.AW(AW)) bus ();

    mips_ins_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .start_addr (start_addr),
        .finish     (finish),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .word_cnt   (word_cnt),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard and model ----------------
    logic [63:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int m_phase;          // 0 idle, 1 run, 2 drain, 3 done
    int m_cnt;
    logic [31:0] m_addr;
    logic m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_onehot(input logic [6:0] s);
        int n = 0;
        for (int i = 0; i < 7; i++) if (s[i]) n++;
        return n == 1;
    endfunction

    // MIPS assembly from the architectural field layout, lowest class bit wins.
    function automatic logic [31:0] ref_encode(input fld_t f);
        int op_of[7] = '{0, 13, 9, 35, 43, 4, 2};
        longint w;
        for (int k = 0; k < 7; k++) begin
            if (f.sel[k]) begin
                if (k == 6)
                    w = longint'(op_of[k]) * 64'd67108864 + longint'(f.target);
                else if (k == 0)
                    w = longint'(f.rs) * 2097152 + longint'(f.rt) * 65536 +
                        longint'(f.rd) * 2048 + longint'(f.shamt) * 64 + longint'(f.funct);
                else
                    w = longint'(op_of[k]) * 64'd67108864 + longint'(f.rs) * 2097152 +
                        longint'(f.rt) * 65536 + longint'(f.imm);
                return w[31:0];
            end
        end
        return 32'h0;
    endfunction

    function automatic fld_t rand_f();
        fld_t f;
        f = fld_t'({$urandom, $urandom, $urandom});
        if ($urandom_range(0, 7) != 0) f.sel = 7'(1 << $urandom_range(0, 6));
        return f;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_addr  = 32'h0;
        m_err   = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_wen"},   64'(bus.mem_wen),   64'd0);
        chk({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
        chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
        chk({tag, "_busy"},      64'(busy),          64'd0);
        chk({tag, "_done"},      64'(done),          64'd0);
        chk({tag, "_word_cnt"},  64'(word_cnt),      64'd0);
        chk({tag, "_err"},       64'(err),           64'd0);
    endtask

    // ---------------- driver ----------------
    // Called #1 after a rising edge: drive one cycle, check at the falling
    // edge, then advance the model across the next rising edge.
    task automatic step(input bit st, input logic [31:0] saddr, input bit fin,
                        input bit v, input fld_t f, input logic [31:0] exp_word);
        bit acc;
        logic [63:0] e;
        start      = st;
        start_addr = saddr;
        finish     = fin;
        bus.in_valid = v;
        {bus.sel, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct, bus.imm, bus.target} = f;
        @(negedge clk);
        chk("in_ready", 64'(bus.in_ready), 64'((m_phase == 1) && (m_cnt < DEPTH)));
        chk("busy",     64'(busy),     64'(m_phase != 0));
        chk("done",     64'(done),     64'(m_phase == 3));
        chk("word_cnt", 64'(word_cnt), 64'(m_cnt));
`ifdef ENC_ONEHOT_CHECK_EN
        chk("err",      64'(err),      64'(m_err));
`else
        chk("err",      64'(err),      64'd0);
`endif
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mem_wen",   64'(bus.mem_wen),   64'd1);
            chk("mem_addr",  64'(bus.mem_addr),  64'(e[63:32]));
            chk("mem_wdata", 64'(bus.mem_wdata), 64'(e[31:0]));
        end else begin
            chk("mem_wen", 64'(bus.mem_wen), 64'd0);
        end
        acc = v && (m_phase == 1) && (m_cnt < DEPTH);
        if (acc) begin
`ifdef ENC_ONEHOT_CHECK_EN
            if (!is_onehot(f.sel)) m_err = 1'b1;
            else begin
                exp_q.push_back({m_addr, exp_word});
                m_cnt++;
                m_addr = m_addr + 32'd4;
            end
`else
            exp_q.push_back({m_addr, exp_word});
            m_cnt++;
            m_addr = m_addr + 32'd4;
`endif
        end
        case (m_phase)
            0: if (st) begin
                m_phase = 1;
                m_addr  = saddr - (saddr % 4);
                m_cnt   = 0;
                m_err   = 1'b0;
            end
            1: if (fin) m_phase = 2;
            2: m_phase = 3;
            default: m_phase = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        fld_t z = '0;
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, z, 32'h0);
    endtask

    // ---------------- test ----------------
    vec_t tbl[7];
    fld_t f;

    initial begin
        tbl[0] = '{f: '{sel: 7'b0000100, rs: 0,  rt: 8,  rd: 0,  shamt: 0, funct: 0,     imm: 16'h0005, target: 0}, exp: 32'h24080005};
        tbl[1] = '{f: '{sel: 7'b0000010, rs: 0,  rt: 9,  rd: 0,  shamt: 0, funct: 0,     imm: 16'h00FF, target: 0}, exp: 32'h340900FF};
        tbl[2] = '{f: '{sel: 7'b0001000, rs: 29, rt: 8,  rd: 0,  shamt: 0, funct: 0,     imm: 16'h0004, target: 0}, exp: 32'h8FA80004};
        tbl[3] = '{f: '{sel: 7'b0000001, rs: 8,  rt: 9,  rd: 10, shamt: 0, funct: 6'h20, imm: 16'h0,    target: 0}, exp: 32'h01095020};
        tbl[4] = '{f: '{sel: 7'b1000000, rs: 0,  rt: 0,  rd: 0,  shamt: 0, funct: 0,     imm: 16'h0,    target: 26'h0100000}, exp: 32'h08100000};
        tbl[5] = '{f: '{sel: 7'b0010000, rs: 29, rt: 31, rd: 0,  shamt: 0, funct: 0,     imm: 16'h0008, target: 0}, exp: 32'hAFBF0008};
        tbl[6] = '{f: '{sel: 7'b0100000, rs: 1,  rt: 2,  rd: 0,  shamt: 0, funct: 0,     imm: 16'hFFFF, target: 0}, exp: 32'h1022FFFF};

        resetn = 1'b0;
        start = 0; finish = 0; start_addr = '0;
        bus.in_valid = 0;
        {bus.sel, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct, bus.imm, bus.target} = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Session A at 0x100: addiu, ori, lw, rtype back to back.
        step(1, 32'h100, 0, 0, '0, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 1, tbl[i].f, tbl[i].exp);
        step(0, 32'h0, 1, 0, '0, 32'h0);
        idle_cycles(3);

        // Session B at 0x203 (low bits dropped): jump, sw, then beq with finish.
        step(1, 32'h203, 0, 0, '0, 32'h0);
        step(0, 32'h0, 0, 1, tbl[4].f, tbl[4].exp);
        step(0, 32'h0, 0, 1, tbl[5].f, tbl[5].exp);
        step(0, 32'h0, 1, 1, tbl[6].f, tbl[6].exp);
        idle_cycles(3);

        // Full: six offered words, only DEPTH accepted; stray start ignored.
        step(1, 32'h400, 0, 0, '0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            f = rand_f();
            f.sel = 7'(1 << (i % 7));
            step(i == 3, 32'h800, 0, 1, f, ref_encode(f));
        end
        step(0, 32'h0, 1, 1, tbl[0].f, tbl[0].exp);
        idle_cycles(3);

        // Illegal selects (multi-hot then zero), address wrap across 2^32.
        step(1, 32'hFFFF_FFF9, 0, 0, '0, 32'h0);
        f = tbl[3].f; f.sel = 7'b0000011;
        step(0, 32'h0, 0, 1, f, ref_encode(f));
        f.sel = 7'b0000000;
        step(0, 32'h0, 0, 1, f, ref_encode(f));
        step(0, 32'h0, 0, 1, tbl[1].f, tbl[1].exp);
        step(0, 32'h0, 0, 1, tbl[2].f, tbl[2].exp);
        step(0, 32'h0, 1, 0, '0, 32'h0);
        idle_cycles(3);

        // Reset mid-session with a write on the port.
        step(1, 32'h40, 0, 0, '0, 32'h0);
        step(0, 32'h0, 0, 1, tbl[0].f, tbl[0].exp);
        #1;
        resetn = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle_cycles(2);

        // Random sessions with stray start/finish and random gaps.
        for (int s = 0; s < 25; s++) begin
            logic [31:0] sa;
            int len;
            sa  = (s % 4 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            len = $urandom_range(1, 9);
            step($urandom_range(0, 1), sa, 1, 0, '0, 32'h0);
            for (int c = 0; c < len; c++) begin
                f = rand_f();
                step($urandom_range(0, 3) == 0, $urandom, (c == len - 1),
                     $urandom_range(0, 3) != 0, f, ref_encode(f));
            end
            idle_cycles($urandom_range(2, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
